branch_resolver: RTL and testbench
==================================

# branch_resolver

Write-side companion to the fetch-stage predictor: accepts resolved control transfers from the execute stage, detects mispredictions, issues a registered redirect to fetch, and maintains a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Fetch reads the same BTB through a combinational lookup port. The block sits between EX (resolution) and IF (lookup/redirect).

## Interface
- IDX_BITS, 4, BTB index width; 2^IDX_BITS entries.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- res_valid  in  1  EX presents a resolved branch/jump this cycle.
- res_pc4  in  32  pc+4 of the resolved instruction.
- res_taken  in  1  actual direction.
- res_target  in  32  actual taken target.
- res_pred_taken  in  1  direction predicted at fetch.
- res_pred_target  in  32  target predicted at fetch.
- lookup_pc4  in  32  fetch pc+4 to look up.
- lookup_hit  out  1  predict taken (combinational).
- lookup_target  out  32  predicted target; 0 when lookup_hit=0.
- redirect  out  1  one-cycle pulse: fetch must restart at redirect_pc.
- redirect_pc  out  32  restart address.
- stat_branches  out  32  accepted resolutions (only with BR_STATS_EN).
- stat_mispredicts  out  32  mispredictions (only with BR_STATS_EN).

## Operation
- Index = pc4[IDX_BITS+1:2]; tag = pc4[31:IDX_BITS+2]. Entry = {valid, tag, target[31:0], ctr[1:0]}.
- Lookup: match = valid && tag equal; lookup_hit = match && ctr[1]; lookup_target = target when lookup_hit, else 32'b0.
- Accept: resolution accepted when res_valid=1 and redirect=0. While redirect=1, res_valid is a wrong-path instruction: ignored entirely (no update, no redirect, no stats).
- Mispredict = (res_taken != res_pred_taken) || (res_taken && res_pred_target != res_target).
- On accepted mispredict: next edge redirect<=1, redirect_pc <= res_taken ? res_target : res_pc4. Otherwise redirect<=0; redirect_pc holds.
- BTB update on accepted resolution, indexed by res_pc4:
  - taken, match: ctr saturating increment (max 2'b11); target <= res_target.
  - taken, no match: allocate/replace: valid=1, tag, target=res_target, ctr=2'b10.
  - not taken, match: ctr saturating decrement (min 2'b00); entry stays valid.
  - not taken, no match: no change.
- Reset: all valid bits 0, all ctr 0, redirect 0, redirect_pc 0, stats 0. Reset has priority over any concurrent resolution; a pending redirect is dropped.

## Timing
- Lookup: 0-cycle combinational from lookup_pc4 and table state.
- Update: written at the edge ending the accept cycle; visible to lookup the following cycle. Same-cycle lookup of the index being written returns the old contents (no bypass).
- Redirect: asserted exactly 1 cycle after the accepted mispredict, held for exactly 1 cycle.
- Throughput: one resolution per cycle; back-to-back resolutions to the same index each see the prior update.
- Cycle after a redirect pulse: res_valid accepted normally.

## Configuration
- BR_STATS_EN defined: stat_branches increments per accepted resolution; stat_mispredicts increments per accepted mispredict; both wrap modulo 2^32, reset to 0.
- Not defined: both stat ports and counters are absent; all other behaviour identical.

## Test plan
- Reset then lookup_pc4=0x104 -> lookup_hit=0, lookup_target=0, redirect=0, redirect_pc=0.
- Accept res_pc4=0x104, taken, target 0x200, pred not-taken -> next cycle redirect=1, redirect_pc=0x200; following cycle lookup 0x104 -> hit=1, target=0x200 (ctr=2'b10).
- Same branch not-taken, pred taken 0x200 -> redirect_pc=0x104, ctr=2'b01, lookup 0x104 -> hit=0; two more taken resolutions -> ctr=2'b11, third taken holds 2'b11.
- Mispredict at cycle N, different res_valid at N+1 (redirect=1) -> N+1 ignored: no BTB change, no second redirect, stats unchanged.
- res_pc4=0x144 (same index as 0x104, different tag) taken to 0x300 -> entry replaced; lookup 0x104 -> hit=0, lookup 0x144 -> target 0x300.
- BR_STATS_EN: 5 accepted resolutions with 2 mispredicts -> stat_branches=5, stat_mispredicts=2; rst=0 mid-redirect -> redirect=0 and counters 0 next cycle.

Source files
------------

// File: rtl/branch_resolver_if.sv
// EX->resolver resolution bus, IF lookup port and redirect back to fetch.
// Stat counters are present only when BR_STATS_EN is defined.
interface branch_resolver_if;
  logic        res_valid;
  logic [31:0] res_pc4;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic [31:0] lookup_pc4;
  logic        lookup_hit;
  logic [31:0] lookup_target;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef BR_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  modport master (
`ifdef BR_STATS_EN
    input  stat_branches, stat_mispredicts,
`endif
    output res_valid, res_pc4, res_taken, res_target, res_pred_taken, res_pred_target,
    output lookup_pc4,
    input  lookup_hit, lookup_target, redirect, redirect_pc
  );

  modport slave (
`ifdef BR_STATS_EN
    output stat_branches, stat_mispredicts,
`endif
    input  res_valid, res_pc4, res_taken, res_target, res_pred_taken, res_pred_target,
    input  lookup_pc4,
    output lookup_hit, lookup_target, redirect, redirect_pc
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolution: mispredict detect, registered redirect, direct-mapped BTB
// with 2-bit counters. Optional stat counters under BR_STATS_EN.
module branch_resolver #(
  parameter int IDX_BITS = 4
) (
  input logic            clk,
  input logic            rst,
  branch_resolver_if.slave br
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t btb [ENTRIES];

  logic        redirect_q;
  logic [31:0] redirect_pc_q;

  // fetch-side lookup, purely combinational on current table state
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic                lk_match;
  assign lk_idx   = br.lookup_pc4[IDX_BITS+1:2];
  assign lk_tag   = br.lookup_pc4[31:IDX_BITS+2];
  assign lk_match = btb[lk_idx].valid && (btb[lk_idx].tag == lk_tag);
  assign br.lookup_hit    = lk_match && btb[lk_idx].ctr[1];
  assign br.lookup_target = br.lookup_hit ? btb[lk_idx].target : 32'b0;

  // resolution side; anything arriving during a redirect is wrong-path
  logic [IDX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]    wr_tag;
  logic                wr_match, accept, mispredict;
  assign wr_idx     = br.res_pc4[IDX_BITS+1:2];
  assign wr_tag     = br.res_pc4[31:IDX_BITS+2];
  assign wr_match   = btb[wr_idx].valid && (btb[wr_idx].tag == wr_tag);
  assign accept     = br.res_valid && !redirect_q;
  assign mispredict = (br.res_taken != br.res_pred_taken) ||
                      (br.res_taken && (br.res_pred_target != br.res_target));

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{br.res_pc4[1:0], br.lookup_pc4[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i].valid <= 1'b0;
        btb[i].ctr   <= 2'b00;
      end
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'b0;
    end else begin
      redirect_q <= accept && mispredict;
      if (accept && mispredict)
        redirect_pc_q <= br.res_taken ? br.res_target : br.res_pc4;
      if (accept) begin
        if (br.res_taken) begin
          if (wr_match) begin
            btb[wr_idx].ctr    <= (btb[wr_idx].ctr == 2'b11) ? 2'b11 : btb[wr_idx].ctr + 2'd1;
            btb[wr_idx].target <= br.res_target;
          end else begin
            btb[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: br.res_target, ctr: 2'b10};
          end
        end else if (wr_match) begin
          btb[wr_idx].ctr <= (btb[wr_idx].ctr == 2'b00) ? 2'b00 : btb[wr_idx].ctr - 2'd1;
        end
      end
    end
  end

  assign br.redirect    = redirect_q;
  assign br.redirect_pc = redirect_pc_q;

`ifdef BR_STATS_EN
  logic [31:0] branches_q, mispredicts_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      branches_q    <= 32'b0;
      mispredicts_q <= 32'b0;
    end else if (accept) begin
      branches_q <= branches_q + 32'd1;
      if (mispredict) mispredicts_q <= mispredicts_q + 32'd1;
    end
  end
  assign br.stat_branches    = branches_q;
  assign br.stat_mispredicts = mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// Directed walk through the resolver's key scenarios, then random traffic
// compared against an array-based BTB/redirect reference model.
module tb_branch_resolver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_resolver_if bus();
  branch_resolver #(.IDX_BITS(4)) dut (.clk(clk), .rst(rst), .br(bus));

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit        mv   [16];
  bit [25:0] mtag [16];
  bit [31:0] mtgt [16];
  int        mctr [16];
  bit        m_redir;
  bit [31:0] m_rpc, m_br, m_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_lookup(input bit [31:0] pc, output bit hit, output bit [31:0] tgt);
    int idx;
    idx = (pc >> 2) % 16;
    hit = mv[idx] && (mtag[idx] == pc[31:6]) && (mctr[idx] >= 2);
    tgt = hit ? mtgt[idx] : 32'h0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin mv[i] = 0; mctr[i] = 0; end
    m_redir = 0; m_rpc = 0; m_br = 0; m_mis = 0;
  endtask

  // drive one cycle's inputs and check outputs half a cycle later
  task automatic drive(input bit r, input bit v, input bit [31:0] pc4, input bit t,
                       input bit [31:0] tgt, input bit pt, input bit [31:0] ptg,
                       input bit [31:0] lpc);
    bit e_hit;
    bit [31:0] e_tgt;
    rst = r;
    bus.res_valid = v; bus.res_pc4 = pc4; bus.res_taken = t; bus.res_target = tgt;
    bus.res_pred_taken = pt; bus.res_pred_target = ptg; bus.lookup_pc4 = lpc;
    #4;
    model_lookup(lpc, e_hit, e_tgt);
    chk("lookup_hit", {31'b0, bus.lookup_hit}, {31'b0, e_hit});
    chk("lookup_target", bus.lookup_target, e_tgt);
    chk("redirect", {31'b0, bus.redirect}, {31'b0, m_redir});
    chk("redirect_pc", bus.redirect_pc, m_rpc);
`ifdef BR_STATS_EN
    chk("stat_branches", bus.stat_branches, m_br);
    chk("stat_mispredicts", bus.stat_mispredicts, m_mis);
`endif
  endtask

  // clock edge; model follows the rules on the values currently driven
  task automatic tick();
    bit acc, mp, match;
    int idx;
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      acc = bus.res_valid && !m_redir;
      mp  = (bus.res_taken != bus.res_pred_taken) ||
            (bus.res_taken && bus.res_pred_target != bus.res_target);
      m_redir = acc && mp;
      if (acc && mp) m_rpc = bus.res_taken ? bus.res_target : bus.res_pc4;
      if (acc) begin
        m_br++;
        if (mp) m_mis++;
        idx   = (bus.res_pc4 >> 2) % 16;
        match = mv[idx] && (mtag[idx] == bus.res_pc4[31:6]);
        if (bus.res_taken) begin
          if (match) begin
            mctr[idx] = (mctr[idx] + 1 > 3) ? 3 : mctr[idx] + 1;
            mtgt[idx] = bus.res_target;
          end else begin
            mv[idx] = 1; mtag[idx] = bus.res_pc4[31:6];
            mtgt[idx] = bus.res_target; mctr[idx] = 2;
          end
        end else if (match) begin
          mctr[idx] = (mctr[idx] - 1 < 0) ? 0 : mctr[idx] - 1;
        end
      end
    end
    #1;
  endtask

  task automatic step(input bit r, input bit v, input bit [31:0] pc4, input bit t,
                      input bit [31:0] tgt, input bit pt, input bit [31:0] ptg,
                      input bit [31:0] lpc);
    drive(r, v, pc4, t, tgt, pt, ptg, lpc);
    tick();
  endtask

  initial begin
    bit [31:0] pc, lpc, tgt, ptg;
    bit t, pt, v, r, phit;
    bus.res_valid = 0; bus.res_pc4 = 0; bus.res_taken = 0; bus.res_target = 0;
    bus.res_pred_taken = 0; bus.res_pred_target = 0; bus.lookup_pc4 = 0;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset state, then taken mispredict to 0x200
    drive(1, 1, 32'h104, 1, 32'h200, 0, 0, 32'h104);
    chk("rst_hit", {31'b0, bus.lookup_hit}, 32'h0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 32'h104);
    chk("tp_redirect", {31'b0, bus.redirect}, 32'h1);
    chk("tp_redirect_pc", bus.redirect_pc, 32'h200);
    chk("tp_hit_target", bus.lookup_target, 32'h200);
    tick();
    // not-taken mispredict -> restart at pc4, counter drops below taken threshold
    step(1, 1, 32'h104, 0, 0, 1, 32'h200, 32'h104);
    drive(1, 0, 0, 0, 0, 0, 0, 32'h104);
    chk("nt_redirect_pc", bus.redirect_pc, 32'h104);
    chk("nt_hit", {31'b0, bus.lookup_hit}, 32'h0);
    tick();
    repeat (3) step(1, 1, 32'h104, 1, 32'h200, 1, 32'h200, 32'h104);
    // mispredict then a wrong-path resolution during the redirect
    step(1, 1, 32'h108, 1, 32'h400, 0, 0, 32'h108);
    step(1, 1, 32'h10c, 1, 32'h500, 0, 0, 32'h108);
    drive(1, 0, 0, 0, 0, 0, 0, 32'h10c);
    chk("wrongpath_redirect", {31'b0, bus.redirect}, 32'h0);
    chk("wrongpath_hit", {31'b0, bus.lookup_hit}, 32'h0);
    tick();
    // alias replacement at the same index
    step(1, 1, 32'h144, 1, 32'h300, 0, 0, 32'h144);
    step(1, 0, 0, 0, 0, 0, 0, 32'h104);
    drive(1, 0, 0, 0, 0, 0, 0, 32'h144);
    chk("alias_target", bus.lookup_target, 32'h300);
    tick();
    // reset while a redirect is pending
    step(1, 1, 32'h118, 1, 32'h600, 0, 0, 32'h118);
    step(0, 1, 32'h118, 1, 32'h600, 0, 0, 32'h118);
    drive(1, 0, 0, 0, 0, 0, 0, 32'h118);
    chk("rst_drop_redirect", {31'b0, bus.redirect}, 32'h0);
    tick();

    // random traffic over a small pc pool so aliases and repeats are common
    for (int i = 0; i < 2000; i++) begin
      r   = ($urandom % 200) != 0;
      v   = ($urandom % 4) != 0;
      pc  = (($urandom % 3) << 6) | (($urandom % 16) << 2);
      lpc = (($urandom % 3) << 6) | (($urandom % 16) << 2);
      t   = $urandom % 2;
      tgt = 32'h200 + (($urandom % 3) << 8);
      if ($urandom % 2) begin
        model_lookup(pc, phit, ptg);
        pt = phit;
      end else begin
        pt  = $urandom % 2;
        ptg = 32'h200 + (($urandom % 3) << 8);
      end
      step(r, v, pc, t, tgt, pt, ptg, lpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
